// File: rtl/seq_multiplier16_pkg.sv
// Shared constants and state encoding for the 16x16 shift-add multiplier.
package seq_multiplier16_pkg;

  localparam int OP_W       = 16;
  localparam int PROD_W     = 32;
  localparam int ITERATIONS = 16;
  localparam int COUNT_W    = 5;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } mulState_t;

endpackage

// File: rtl/seq_multiplier16_adder.sv
// 16-bit carry-lookahead adder: 4-bit groups with a fully expanded group-carry level.
module CarryLookAheadAdder16
  import seq_multiplier16_pkg::*;
(
  input  logic [OP_W-1:0] a,
  input  logic [OP_W-1:0] b,
  input  logic            cIn,
  output logic [OP_W-1:0] sum,
  output logic            cOut,
  output logic            groupProp,
  output logic            groupGen
);

  localparam int GROUPS = OP_W / 4;

  logic [OP_W-1:0]   bitProp;
  logic [OP_W-1:0]   bitGen;
  logic [GROUPS-1:0] blkProp;
  logic [GROUPS-1:0] blkGen;
  logic [GROUPS:0]   grpCarry;

  assign bitProp = a ^ b;
  assign bitGen  = a & b;

  genvar gi;
  generate
    for (gi = 0; gi < GROUPS; gi++) begin : gGroup
      localparam int LSB = 4 * gi;
      logic c1, c2, c3;

      assign blkProp[gi] = &bitProp[LSB +: 4];
      assign blkGen[gi]  = bitGen[LSB+3]
                         | (bitProp[LSB+3] & bitGen[LSB+2])
                         | (&bitProp[LSB+2 +: 2] & bitGen[LSB+1])
                         | (&bitProp[LSB+1 +: 3] & bitGen[LSB]);

      assign c1 = bitGen[LSB] | (bitProp[LSB] & grpCarry[gi]);
      assign c2 = bitGen[LSB+1] | (bitProp[LSB+1] & bitGen[LSB])
                | (&bitProp[LSB +: 2] & grpCarry[gi]);
      assign c3 = bitGen[LSB+2] | (bitProp[LSB+2] & bitGen[LSB+1])
                | (&bitProp[LSB+1 +: 2] & bitGen[LSB])
                | (&bitProp[LSB +: 3] & grpCarry[gi]);

      assign sum[LSB +: 4] = bitProp[LSB +: 4] ^ {c3, c2, c1, grpCarry[gi]};
    end
  endgenerate

  // Group carries depend only on group P/G and cIn, never on each other.
  assign grpCarry[0] = cIn;
  assign grpCarry[1] = blkGen[0] | (blkProp[0] & cIn);
  assign grpCarry[2] = blkGen[1] | (blkProp[1] & blkGen[0]) | (&blkProp[1:0] & cIn);
  assign grpCarry[3] = blkGen[2] | (blkProp[2] & blkGen[1]) | (&blkProp[2:1] & blkGen[0])
                     | (&blkProp[2:0] & cIn);
  assign grpCarry[4] = blkGen[3] | (blkProp[3] & blkGen[2]) | (&blkProp[3:2] & blkGen[1])
                     | (&blkProp[3:1] & blkGen[0]) | (&blkProp[3:0] & cIn);

  assign cOut      = grpCarry[GROUPS];
  assign groupProp = &blkProp;
  assign groupGen  = blkGen[3] | (blkProp[3] & blkGen[2]) | (&blkProp[3:2] & blkGen[1])
                   | (&blkProp[3:1] & blkGen[0]);

endmodule

// File: rtl/seq_multiplier16.sv
// Sequential 16x16 unsigned shift-add multiplier; one result every 17 cycles.
module seq_multiplier16
  import seq_multiplier16_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [OP_W-1:0]   in1,
  input  logic [OP_W-1:0]   in2,
  output logic              busy,
  output logic              done,
  output logic [PROD_W-1:0] product
);

  localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(ITERATIONS - 1);

  mulState_t           stateReg, stateNext;
  logic [PROD_W-1:0]   accReg, accNext;
  logic [OP_W-1:0]     mcandReg, mcandNext;
  logic [COUNT_W-1:0]  countReg, countNext;
  logic [PROD_W-1:0]   productReg, productNext;

  logic [OP_W-1:0]     addSum;
  logic                addCarry;
  logic [OP_W:0]       stepHigh;
  logic                unusedGroupProp;
  logic                unusedGroupGen;

  CarryLookAheadAdder16 adder (
    .a         (accReg[PROD_W-1:OP_W]),
    .b         (mcandReg),
    .cIn       (1'b0),
    .sum       (addSum),
    .cOut      (addCarry),
    .groupProp (unusedGroupProp),
    .groupGen  (unusedGroupGen)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg   <= IDLE;
      accReg     <= '0;
      mcandReg   <= '0;
      countReg   <= '0;
      productReg <= '0;
    end else begin
      stateReg   <= stateNext;
      accReg     <= accNext;
      mcandReg   <= mcandNext;
      countReg   <= countNext;
      productReg <= productNext;
    end
  end

  always_comb begin
    stateNext   = stateReg;
    accNext     = accReg;
    mcandNext   = mcandReg;
    countNext   = countReg;
    productNext = productReg;
    // Carry-out lands in bit 31 after the shift, so the product never overflows.
    stepHigh    = accReg[0] ? {addCarry, addSum} : {1'b0, accReg[PROD_W-1:OP_W]};

    case (stateReg)
      IDLE, DONE: begin
        if (start) begin
          stateNext = RUN;
          mcandNext = in1;
          accNext   = {{OP_W{1'b0}}, in2};
          countNext = '0;
        end else begin
          stateNext = IDLE;
        end
      end
      RUN: begin
        accNext   = {stepHigh, accReg[OP_W-1:1]};
        countNext = countReg + COUNT_W'(1);
        if (countReg == LAST_COUNT) begin
          productNext = {stepHigh, accReg[OP_W-1:1]};
          stateNext   = DONE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign busy    = (stateReg == RUN);
  assign done    = (stateReg == DONE);
  assign product = productReg;

endmodule
